// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the Booth multiplier output stage.
package booth_pkg;

  localparam int COEF_W = 8;

  typedef logic signed [COEF_W-1:0] booth_coef_t;

  // Rounding bias for an arithmetic right shift by `shift` bits.
  function automatic int ROUND_HALF(input int shift);
    return 1 << (shift - 1);
  endfunction

  function automatic int CNT_W(input int depth, input int lat);
    return $clog2(depth + lat + 1);
  endfunction

endpackage

// File: rtl/booth_quant_fifo.sv
// Synchronous FIFO with registered storage; the head entry drives rd_data directly.
module booth_quant_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  // A read in the same cycle frees the slot, so a write while full still lands.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_en);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_quant_out.sv
// Booth product round/saturate/buffer stage with issue credit accounting.
// Saturation is enabled by defining BOOTH_QUANT_SAT_EN; otherwise the coefficient wraps.
module booth_quant_out
  import booth_pkg::*;
#(
  parameter int PW    = 18,
  parameter int OW    = 8,
  parameter int SHIFT = 7,
  parameter int DEPTH = 4,
  parameter int LAT   = 5
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          issue_fire,
  output logic          issue_ready,
  input  logic [PW-1:0] din_product,
  input  logic          din_valid,
  output logic [OW-1:0] dout_data,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          sat_flag,
  output logic          err_unexp
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = CNT_W(DEPTH, LAT);
  localparam int OCW = CW + 1;

  // Rounding at PW+1 bits so the bias add cannot overflow.
  logic signed [PW:0] p_ext;
  logic signed [PW:0] half;
  logic signed [PW:0] half_m1;
  logic signed [PW:0] r_sum;
  logic [OW-1:0]      coef;

  assign half    = (PW+1)'(ROUND_HALF(SHIFT));
  assign half_m1 = (PW+1)'(ROUND_HALF(SHIFT) - 1);

  always_comb begin
    p_ext = {din_product[PW-1], din_product};
    r_sum = p_ext + (din_product[PW-1] ? half_m1 : half);
  end

`ifdef BOOTH_QUANT_SAT_EN
  logic signed [PW:0] r_val;
  logic signed [PW:0] r_max;
  logic signed [PW:0] r_min;
  logic               sat_hit;

  assign r_max = (PW+1)'((1 << (OW - 1)) - 1);
  assign r_min = (PW+1)'(-(1 << (OW - 1)));

  always_comb begin
    r_val   = r_sum >>> SHIFT;
    coef    = r_val[OW-1:0];
    sat_hit = 1'b0;
    if (r_val > r_max) begin
      coef    = r_max[OW-1:0];
      sat_hit = 1'b1;
    end else if (r_val < r_min) begin
      coef    = r_min[OW-1:0];
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sat_flag <= 1'b0;
    end else if (din_valid && sat_hit) begin
      sat_flag <= 1'b1;
    end
  end
`else
  always_comb begin
    coef = OW'(r_sum >>> SHIFT);
  end

  assign sat_flag = 1'b0;
`endif

  // Round register
  logic          rr_valid;
  logic [OW-1:0] rr_data;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rr_valid <= 1'b0;
      rr_data  <= '0;
    end else begin
      rr_valid <= din_valid;
      if (din_valid) begin
        rr_data <= coef;
      end
    end
  end

  // Output FIFO
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;

  booth_quant_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OW)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (rr_valid),
    .wr_data (rr_data),
    .rd_en   (dout_ready),
    .rd_data (dout_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign dout_valid = !fifo_empty;

  // Credit accounting: every slot a product might need is reserved at issue.
  logic [CW-1:0]  inflight;
  logic [OCW-1:0] occ;
  logic           issue_ok;
  logic           din_exp;
  logic           din_unexp;
  logic           wr_drop;

  assign occ         = OCW'(inflight) + OCW'(rr_valid) + OCW'(fifo_count);
  assign issue_ready = (occ < OCW'(DEPTH));
  assign issue_ok    = issue_fire && issue_ready;
  assign din_exp     = din_valid && (inflight != '0);
  assign din_unexp   = din_valid && (inflight == '0);
  assign wr_drop     = rr_valid && fifo_full && !dout_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      inflight  <= '0;
      err_unexp <= 1'b0;
    end else begin
      inflight <= inflight + CW'(issue_ok) - CW'(din_exp);
      if (din_unexp || wr_drop) begin
        err_unexp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_quant_out.sv
// Directed bench for booth_quant_out; expectations follow BOOTH_QUANT_SAT_EN if defined.
`timescale 1ns/1ps
module tb_booth_quant_out;

  localparam int PW = 18;
  localparam int OW = 8;

`ifdef BOOTH_QUANT_SAT_EN
  localparam int SAT_EN = 1;
`else
  localparam int SAT_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          issue_fire = 1'b0;
  logic          issue_ready;
  logic [PW-1:0] din_product = '0;
  logic          din_valid = 1'b0;
  logic [OW-1:0] dout_data;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          sat_flag;
  logic          err_unexp;

  int vec_cnt = 0;
  int miscmp  = 0;

  always #5 clk = ~clk;

  booth_quant_out #(
    .PW    (PW),
    .OW    (OW),
    .SHIFT (7),
    .DEPTH (4),
    .LAT   (5)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .issue_fire  (issue_fire),
    .issue_ready (issue_ready),
    .din_product (din_product),
    .din_valid   (din_valid),
    .dout_data   (dout_data),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .sat_flag    (sat_flag),
    .err_unexp   (err_unexp)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One issue, one product, then check latency, value, and pop it.
  task automatic run_vec(input string tag, input int p, input int exp_d);
    issue_fire = 1'b1;
    cyc();
    issue_fire  = 1'b0;
    din_valid   = 1'b1;
    din_product = PW'(p);
    cyc();
    din_valid = 1'b0;
    check({tag, "_lat1"}, dout_valid, 0);
    cyc();
    check({tag, "_vld"}, dout_valid, 1);
    check(tag, $signed(dout_data), exp_d);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[4];

    // Reset state
    cyc();
    cyc();
    check("rst_dvalid", dout_valid, 0);
    check("rst_ddata", $signed(dout_data), 0);
    check("rst_irdy", issue_ready, 1);
    check("rst_sat", sat_flag, 0);
    check("rst_err", err_unexp, 0);
    nrst = 1'b1;
    cyc();

    // Rounding, half away from zero
    run_vec("r192", 192, 2);
    run_vec("rm192", -192, -2);
    run_vec("r12700", 12700, 99);
    run_vec("rm16256", -16256, -127);
    check("round_sat", sat_flag, 0);
    check("round_err", err_unexp, 0);

    // Saturation or wrap
    run_vec("s20000", 20000, SAT_EN ? 127 : -100);
    check("s20000_flag", sat_flag, SAT_EN);
    run_vec("sm20000", -20000, SAT_EN ? -128 : 100);
    check("sm20000_flag", sat_flag, SAT_EN);

    // Credit: four issues fill the budget
    dout_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("cr_rdy", issue_ready, 1);
      issue_fire = 1'b1;
      cyc();
    end
    issue_fire = 1'b0;
    check("cr_block", issue_ready, 0);
    issue_fire = 1'b1;  // ignored: no credit
    cyc();
    issue_fire = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      din_valid   = 1'b1;
      din_product = PW'(128 * k);
      cyc();
    end
    din_valid = 1'b0;
    cyc();
    check("cr_full_vld", dout_valid, 1);
    check("cr_head", $signed(dout_data), 1);
    check("cr_still_blk", issue_ready, 0);
    check("cr_err", err_unexp, 0);
    cyc();
    check("cr_hold", $signed(dout_data), 1);
    dout_ready = 1'b1;
    cyc();
    dout_ready = 1'b0;
    check("cr_release", issue_ready, 1);
    check("cr_next", $signed(dout_data), 2);

    // Simultaneous issue and arrival; FIFO holds 2,3,4
    issue_fire = 1'b1;
    dout_ready = 1'b1;
    cyc();
    check("sim_rdy", issue_ready, 1);
    check("sim_head", $signed(dout_data), 3);
    issue_fire  = 1'b1;
    din_valid   = 1'b1;
    din_product = PW'(640);
    dout_ready  = 1'b0;
    cyc();
    check("sim_occ", issue_ready, 0);
    issue_fire  = 1'b0;
    din_valid   = 1'b1;
    din_product = PW'(768);
    cyc();
    din_valid = 1'b0;
    check("sim_inflight", err_unexp, 0);
    cyc();
    check("sim_full_vld", dout_valid, 1);
    check("sim_full_head", $signed(dout_data), 3);
    check("sim_full_blk", issue_ready, 0);

    // Unexpected product while full, popped in the same cycle it is written
    din_valid   = 1'b1;
    din_product = PW'(896);
    cyc();
    din_valid = 1'b0;
    check("err_set", err_unexp, 1);
    dout_ready = 1'b1;
    cyc();
    check("pw_blk", issue_ready, 0);
    exp_seq = '{4, 5, 6, 7};
    for (int k = 0; k < 4; k++) begin
      check("pw_vld", dout_valid, 1);
      check("pw_data", $signed(dout_data), exp_seq[k]);
      cyc();
    end
    check("pw_empty", dout_valid, 0);
    dout_ready = 1'b0;
    cyc();
    check("err_sticky", err_unexp, 1);
    check("drain_rdy", issue_ready, 1);

    // Asynchronous reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      issue_fire = 1'b1;
      cyc();
    end
    issue_fire = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      din_valid   = 1'b1;
      din_product = PW'(128 * k);
      cyc();
    end
    din_valid = 1'b0;
    cyc();
    check("mid_vld", dout_valid, 1);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_vld", dout_valid, 0);
    check("arst_rdy", issue_ready, 1);
    check("arst_err", err_unexp, 0);
    check("arst_sat", sat_flag, 0);
    check("arst_data", $signed(dout_data), 0);
    cyc();
    nrst = 1'b1;
    cyc();
    run_vec("post_rst", 12700, 99);
    check("post_rst_err", err_unexp, 0);
    check("post_rst_empty", dout_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/booth_quant_out.md
# booth_quant_out

Output stage placed directly after the last `booth_algo` step of the pipelined Booth multiplier in the JPEG quantiser datapath. It takes the raw signed product from the final stage and converts it to the output coefficient:
- rounds it by an arithmetic right shift, rounding half away from zero;
- saturates it to the output width;
- buffers it in a small FIFO with a valid/ready output.

The Booth pipeline has no stall. This block therefore runs credit accounting so the issuing stage never launches a multiply that the FIFO cannot absorb.

## Interface
Parameters:
- `PW`, 18, product width (signed).
- `OW`, 8, output coefficient width (signed).
- `SHIFT`, 7, right-shift amount applied to the product, at least 1.
- `DEPTH`, 4, FIFO depth; must be a power of 2 and at least 2.
- `LAT`, 5, Booth pipeline latency from issue to `din_valid`; used only for counter sizing.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `issue_fire`  in  1  upstream launched a multiply this cycle.
- `issue_ready`  out  1  upstream may launch this cycle.
- `din_product`  in  PW  signed product from the final Booth step.
- `din_valid`  in  1  product valid; no backpressure.
- `dout_data`  out  OW  rounded and saturated coefficient.
- `dout_valid`  out  1  FIFO head valid.
- `dout_ready`  in  1  downstream accepts.
- `sat_flag`  out  1  sticky: saturation occurred.
- `err_unexp`  out  1  sticky: `din_valid` arrived with no multiply in flight, or with the FIFO full.

## Operation
Round stage (registered):
- If the product is ≥ 0: `r = (p + 2^(SHIFT-1)) >>> SHIFT`.
- If the product is < 0: `r = (p + 2^(SHIFT-1) - 1) >>> SHIFT`.
- Compute at PW+1 bits so the add cannot overflow.

Saturation:
- Clamp `r` to the range [-2^(OW-1), 2^(OW-1)-1].
- Set `sat_flag` when the clamp changes the value.

Round register:
- Holds `rr_data` and `rr_valid`.
- Loads on every clock edge with `din_valid`.
- Its content is written into the FIFO on the following edge. The write always succeeds because credits are reserved at issue time.

Credit accounting:
- `inflight` counts issued multiplies not yet seen at `din_valid`.
- It increments on `issue_fire` and decrements on `din_valid`.
- When both occur together it is unchanged.
- `occ = inflight + rr_valid + fifo_count`.
- `issue_ready = (occ < DEPTH)`, combinational from registers only.
- `issue_fire` while `issue_ready` is 0 is ignored: the counter does not increment.

Error conditions:
- `din_valid` with `inflight == 0`: set `err_unexp`, drop the counter decrement, still process the data.
- Write with the FIFO full: set `err_unexp` and drop the write.

FIFO:
- Read and write pointers are `log2(DEPTH)+1` bits; full/empty is decided by comparing the MSBs.
- The pointers wrap naturally.
- Simultaneous read and write while full: the read frees the slot first, so the write is accepted.
- `dout_data` is the registered FIFO head and holds while `dout_valid && !dout_ready`.

## Timing
- Reset values:
  - `dout_valid` = 0, `dout_data` = 0.
  - `issue_ready` = 1.
  - `sat_flag` = 0, `err_unexp` = 0.
  - All counters, pointers and `rr_valid` = 0.
- Latency: `din_valid` in cycle n gives `dout_valid` in cycle n+2 when the FIFO was empty. Throughput is 1 per cycle.
- Credit release: a FIFO read in cycle n gives `issue_ready` high in cycle n+1 when it was blocked only by occupancy.
- Reset asserted mid-operation: all state clears. Upstream is reset on the same `nrst`, so no stale products arrive.

## Configuration
Macro `BOOTH_QUANT_SAT_EN`:
- Defined: saturation logic as above.
- Undefined:
  - `dout_data` is the low OW bits of `r` (wraps).
  - `sat_flag` is tied to 0.
  - No comparators are synthesised.

## Structure
- Package `booth_pkg` holds:
  - the `booth_coef_t` typedef (`logic signed [OW-1:0]`, default OW);
  - the `ROUND_HALF` helper constant function;
  - the `CNT_W = $clog2(DEPTH+LAT+1)` function.
- One sub-module, `booth_quant_fifo`: a synchronous FIFO with `DEPTH`/`WIDTH` parameters and ports `wr_en`, `rd_en`, `full`, `empty`, `count`.
- Rounding, saturation and credit logic stay in the top level.

## Test plan
Defaults apply (SHIFT=7, OW=8, macro defined) unless a scenario states otherwise.
- Rounding: products 192, -192, 12700, -16256 → `dout_data` = 2, -2, 99, -127. Each appears 2 cycles after its `din_valid`.
- Saturation: 20000 → 127 and -20000 → -128, with `sat_flag` = 1. With the macro undefined, 20000 → -100 (0x9C) and `sat_flag` = 0.
- Credit: issue 4 multiplies with `dout_ready` = 0 → `issue_ready` goes 0 after the 4th. After the products arrive, one pop → `issue_ready` = 1 the next cycle. The FIFO never overflows.
- Simultaneous: `issue_fire` and `din_valid` in the same cycle keep `inflight` unchanged. A pop while full, together with a write, keeps the count at 4.
- Error: `din_valid` pulse with nothing issued → `err_unexp` = 1 and stays 1 until reset.
- Reset mid-burst: `nrst` low with 3 entries queued → `dout_valid` = 0 and `issue_ready` = 1 immediately (asynchronous). Normal streaming resumes after release.
